fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the 9-bit instruction ROM: owns the program counter, its one-shot load start, and a one-entry
//  fetch register with a valid/ready handshake to the decoder. Applies absolute/relative branches and halt.
//  Sits between top-level start/done and the decode stage; drives the ROM's programCounter and start.
// PARAMETERS
//  D            12  PC / ROM address width (ROM depth 2**D)
//  LOAD_CYCLES   2  cycles rom_start held high before fetching begins (>=1)
//  OFF_W         8  width of signed relative branch offset (OFF_W <= D)
// PORTS
//  clk            in   1      single clock; all state on rising edge
//  reset          in   1      asynchronous, active-high; clears all state
//  start          in   1      level; sampled in IDLE/DONE to begin a program run
//  rom_start      out  1      to ROM start input
//  programCounter out  D      ROM address (registered PC)
//  machineCode    in   9      ROM data, combinational from programCounter
//  instr          out  9      fetched instruction
//  instr_pc       out  D      address instr was fetched from
//  instr_valid    out  1      instr holds an unconsumed instruction
//  instr_ready    in   1      decoder consumes instr when instr_valid & instr_ready (=accept)
//  branch_taken   in   1      valid only with accept; redirect fetch
//  branch_rel     in   1      1: target = instr_pc + sext(branch_offset); 0: target = branch_target
//  branch_target  in   D      absolute target
//  branch_offset  in   OFF_W  signed offset
//  halt           in   1      valid only with accept; end program
//  done           out  1      program finished (halt or PC overflow)
//  fault          out  1      finished due to PC overflow
// BEHAVIOUR
//  Reset values: state=IDLE, programCounter=0, instr=0, instr_pc=0, instr_valid=0, rom_start=0, done=0, fault=0.
//  FSM: IDLE -start-> LOAD; LOAD (rom_start=1, count LOAD_CYCLES) -> RUN with PC=0;
//       RUN -(accept&halt) or overflow-> DONE; DONE -start-> LOAD (done, fault cleared on entry to LOAD).
//  rom_start is 1 only in LOAD; it rises on the clock edge entering LOAD (clean posedge to ROM).
//  start is ignored in LOAD and RUN.
//  RUN fetch: load = !instr_valid | accept. On load: instr<=machineCode, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
//   Fetch latency: 1 cycle from PC to instr_valid. Sustains 1 instr/cycle with instr_ready held high.
//   If !instr_valid | accept is false, PC, instr and instr_pc are held (stall).
//  Branch (accept & branch_taken & !halt): PC<=target (mod 2**D, D-bit wrap), instr_valid<=0 (flush the
//   sequential fetch). The first target instr is valid 1 cycle later (1-bubble penalty).
//  Halt (accept & halt): has priority over branch. instr_valid<=0, state->DONE, done=1; PC held.
//  Overflow: a load performed at PC=2**D-1 (no branch/halt) captures that instr normally but sets a pending flag.
//   The next accept of that instr with no branch and no halt -> DONE, fault=1, done=1.
//   A branch or halt on that accept takes precedence over the overflow.
//  instr_valid is never 1 outside RUN. Decoder inputs are ignored unless accept.
//  Reset asserted mid-run: async clear to reset values; a new start is needed (ROM keeps its content).
// STRUCTURE
//  Shared package fetch_pkg: typedef enum logic[1:0] {IDLE,LOAD,RUN,DONE} fetch_state_t; INSTR_W=9.
//  Sub-module fetch_pc_next: combinational next-PC / target mux (incr, abs, rel sign-extend, D-bit wrap).
//  FSM, load counter and fetch register in this module.
// TESTING (D=12, LOAD_CYCLES=2; ROM preloaded with addr-indexed pattern)
//  reset, start=1 -> rom_start=1 for 2 cycles; programCounter 0,1,2..; instr_valid 1 cycle after RUN entry; instr=mem[0].
//  instr_ready=0 for 3 cycles at instr_pc=5 -> instr/instr_pc/programCounter stable; resumes with 6,7.
//  accept at instr_pc=10, branch_taken, abs target=0x200 -> one bubble; next instr_pc=0x200.
//  accept at instr_pc=3, rel offset=-4 (8'hFC) -> next instr_pc=0xFFF (wrap); then accept at 0xFFF, no branch -> done=1, fault=1.
//  accept with halt=1 and branch_taken=1 -> done=1, fault=0, instr_valid=0; start again -> LOAD, done=0, PC=0.
//  reset pulsed in RUN at PC=7 -> all outputs 0 immediately (async); start while RUN ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and instruction width for the fetch sequencer
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} fetch_state_t;
    localparam int INSTR_W = 9;
endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: next-PC mux choosing increment, absolute or sign-extended relative target, D-bit wrap
module fetch_pc_next #(
    parameter int D = 12,
    parameter int OFF_W = 8
) (
    input  logic [D-1:0]     pc,
    input  logic [D-1:0]     instr_pc,
    input  logic [D-1:0]     branch_target,
    input  logic [OFF_W-1:0] branch_offset,
    input  logic             redirect,
    input  logic             branch_rel,
    output logic [D-1:0]     next_pc
);
    logic [D-1:0] rel_target;
    assign rel_target = instr_pc + D'($signed(branch_offset));
    assign next_pc = !redirect ? pc + D'(1) : branch_rel ? rel_target : branch_target;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: ROM load/start sequencing, program counter and one-entry fetch register for the decoder
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int D = 12,
    parameter int LOAD_CYCLES = 2,
    parameter int OFF_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               rom_start,
    output logic [D-1:0]       programCounter,
    input  logic [INSTR_W-1:0] machineCode,
    output logic [INSTR_W-1:0] instr,
    output logic [D-1:0]       instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic               branch_rel,
    input  logic [D-1:0]       branch_target,
    input  logic [OFF_W-1:0]   branch_offset,
    input  logic               halt,
    output logic               done,
    output logic               fault
);
    localparam int CW = $clog2(LOAD_CYCLES + 1);
    fetch_state_t state;
    logic [CW-1:0] cnt;
    logic pend, accept, load, redirect;
    logic [D-1:0] next_pc;
    assign accept = instr_valid & instr_ready;
    assign load = !instr_valid | accept;
    assign redirect = accept & branch_taken & !halt;
    fetch_pc_next #(.D(D), .OFF_W(OFF_W)) u_pc_next (
        .pc(programCounter),
        .instr_pc(instr_pc),
        .branch_target(branch_target),
        .branch_offset(branch_offset),
        .redirect(redirect),
        .branch_rel(branch_rel),
        .next_pc(next_pc)
    );
    // pend marks that the held instruction came from the last ROM address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            pend <= 1'b0;
            programCounter <= '0;
            instr <= '0;
            instr_pc <= '0;
            instr_valid <= 1'b0;
            rom_start <= 1'b0;
            done <= 1'b0;
            fault <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= LOAD;
                    cnt <= '0;
                    rom_start <= 1'b1;
                    done <= 1'b0;
                    fault <= 1'b0;
                    pend <= 1'b0;
                    programCounter <= '0;
                end
                LOAD: if (cnt == CW'(LOAD_CYCLES - 1)) begin
                    state <= RUN;
                    rom_start <= 1'b0;
                    programCounter <= '0;
                end else cnt <= cnt + CW'(1);
                RUN: if (accept & halt) begin
                    state <= DONE;
                    done <= 1'b1;
                    instr_valid <= 1'b0;
                    pend <= 1'b0;
                end else if (redirect) begin
                    programCounter <= next_pc;
                    instr_valid <= 1'b0;
                    pend <= 1'b0;
                end else if (accept & pend) begin
                    state <= DONE;
                    done <= 1'b1;
                    fault <= 1'b1;
                    instr_valid <= 1'b0;
                    pend <= 1'b0;
                end else if (load) begin
                    instr <= machineCode;
                    instr_pc <= programCounter;
                    instr_valid <= 1'b1;
                    programCounter <= next_pc;
                    pend <= &programCounter;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
